fpmul_arbiter: RTL and testbench
================================

# fpmul_arbiter

Round-robin arbiter and sequencer that shares one single-precision floating-point multiplier datapath among `NREQ` requesters. It accepts operand pairs over per-requester valid/ready handshakes and registers them into the multiplier's operand ports. It tracks each operation's requester through a fixed-latency tag pipeline, then returns results in issue order through a credit-protected response FIFO with a single valid/ready output. It sits between the client units and the combinational multiplier instance, which is instantiated alongside it at the next level up.

## Interface
- `NREQ`, 4: number of requesters, 2..8.
- `LAT`, 2: cycles from operand-register load to result capture, ≥1. `LAT-1` is the number of result delay stages.
- `DEPTH`, 4: response FIFO entries and maximum outstanding operations, ≥`LAT`.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `req_valid`  in  NREQ  operand pair offered, one bit per requester.
- `req_ready`  out  NREQ  grant. One-hot or zero.
- `req_a`, `req_b`  in  NREQ×32  IEEE-754 single operands per requester.
- `mul_a`, `mul_b`  out  32  registered operands to the multiplier.
- `mul_op`  in  32  multiplier product (combinational from `mul_a`/`mul_b`).
- `rsp_valid`  out  1  result available.
- `rsp_ready`  in  1  consumer accepts result.
- `rsp_data`  out  32  product.
- `rsp_id`  out  $clog2(NREQ)  index of the originating requester.

## Operation
- **Credit counter `cnt` (0..DEPTH)**: counts in-flight operations plus FIFO occupancy.
  - +1 on a grant, −1 on a response handshake.
  - Both in the same cycle: unchanged.
- **Grant eligibility**: granting is allowed only when `cnt < DEPTH`. The FIFO therefore can never overflow, and the pipeline never stalls.
- **Arbitration**: round-robin pointer `ptr`.
  - Search starts at `ptr`, wraps modulo `NREQ`, and selects the first set `req_valid`.
  - `req_ready[i]` is high only for the selected `i`, and only when the grant is eligible. It is combinational from `req_valid`, `ptr` and `cnt`.
  - After a grant to `i`: `ptr ← (i+1) mod NREQ`. With no grant, `ptr` holds.
- **Issue**: on a grant, `mul_a`/`mul_b` load the granted requester's operands. A tag `{v=1, id}` enters stage 0 of the tag pipeline.
  - With no grant, the operand registers hold and `v=0` enters.
- **Capture**: `mul_op` is sampled alongside tag stage 0 and shifts through `LAT-1` data/tag stages. When the final stage has `v=1`, `{id, data}` is written into the FIFO.
- **Response**: the FIFO is first-word-fall-through with a registered head.
  - `rsp_valid` is high whenever the FIFO is non-empty.
  - A pop occurs on `rsp_valid & rsp_ready`.
  - A simultaneous write and pop is legal at any occupancy, including empty→bypass-free (the write is visible the next cycle) and full.
- **Ordering**: results leave strictly in grant order. `rsp_id` distinguishes requesters.
- **Arithmetic**: the block never inspects or alters operand or result bits. Overflow, NaN and denormal handling belong to the multiplier.

## Timing
- Request handshake in cycle t:
  - `mul_a`/`mul_b` are valid in t+1.
  - The result is written to the FIFO at the end of t+LAT.
  - `rsp_valid` is asserted in t+LAT+1 at the earliest.
- Sustained throughput is one operation per cycle when `rsp_ready` is held high and `DEPTH ≥ LAT+1`.
  - With `DEPTH = LAT`, throughput is bounded by credits; this is allowed and must be correct.
- Reset (asynchronous, any time, including mid-operation):
  - `ptr`, `cnt`, all tag valids and FIFO pointers go to 0.
  - `mul_a`, `mul_b`, `rsp_data`, `rsp_id` go to 0.
  - `rsp_valid` and `req_ready` go to 0.
  - In-flight operations are discarded silently.
- The first grant is possible in the first cycle after `rst_n` deasserts.
- `req_ready` never depends on `rsp_ready` combinationally. The credit check uses the registered `cnt` only.

## Structure
- Package `fpmul_pkg`:
  - `FP_W = 32`.
  - `fp32_t` packed struct `{sign, exp[7:0], frac[22:0]}`.
  - `EXP_BIAS = 127`.
  - A tag typedef `{logic v; logic [ID_W-1:0] id;}` parameterised through a localparam.
  - Ports use `fp32_t` for all 32-bit operand and result signals.
- Sub-module `fpmul_rsp_fifo`: synchronous FIFO with parameters `DEPTH` and data width `ID_W+32`, exposing `full`/`empty` for assertions only.
- Arbiter, credit counter and tag pipeline live in the top module.

## Test plan
- **Single op**: requester 2 sends `a=0x40000000` (2.0), `b=0x40400000` (3.0) with `LAT=2` and `rsp_ready=1`. Expect `rsp_valid` exactly 3 cycles after the handshake, with `rsp_data=0x40C00000` and `rsp_id=2`.
- **All requesters valid continuously from reset**: grants must be 0,1,2,3,0,…, one per cycle, and `rsp_id` must follow the same sequence.
- **Backpressure**: hold `rsp_ready=0`. After exactly `DEPTH`=4 grants, `req_ready` stays 0 and `rsp_valid=1`. Raise `rsp_ready` for one cycle: exactly one more grant follows the next cycle.
- **Simultaneous grant and pop at `cnt=DEPTH-1`**: `cnt` holds, no FIFO overflow, and no result is lost or duplicated (scoreboard compares against a reference model over 1000 random ops).
- **Reset mid-flight**: deassert `rst_n` with 3 ops in the pipeline and FIFO. All outputs go to 0 immediately. After release, `rsp_valid` stays 0 until a new op completes `LAT+1` cycles after its grant.
- **Sparse requests**: only requester 3 is valid, then only requester 1. Each is granted in the cycle it is valid, and `ptr` advances to 0 and then to 2.

Source files
------------

// File: rtl/fpmul_pkg.sv
// Shared types and constants for the fp32 multiplier arbiter and its response FIFO.
package fpmul_pkg;

   localparam int FP_W     = 32;
   localparam int EXP_BIAS = 127;
   localparam int NREQ_MAX = 8;
   localparam int TAG_ID_W = $clog2(NREQ_MAX);

   typedef struct packed {
      logic        sign;
      logic [7:0]  exp;
      logic [22:0] frac;
   } fp32_t;

   typedef struct packed {
      logic                v;
      logic [TAG_ID_W-1:0] id;
   } tag_t;

endpackage

// File: rtl/fpmul_rsp_fifo.sv
// First-word-fall-through response FIFO; head is read straight from the storage registers.
module fpmul_rsp_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 35
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_data,
   output logic             empty,
   output logic             full
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             do_wr, do_rd;

   assign empty   = (count_q == '0);
   assign full    = (count_q == CNT_FULL);
   assign do_rd   = rd_en && !empty;
   // A pop frees the head slot in the same cycle, so a write while full is accepted.
   assign do_wr   = wr_en && (!full || do_rd);
   assign rd_data = mem_q[rd_ptr_q];

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_wr) begin
         mem_d[wr_ptr_q] = wr_data;
         wr_ptr_d        = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_W'(1);
      end
      if (do_rd) begin
         rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_W'(1);
      end
      if (do_wr && !do_rd) begin
         count_d = count_q + CNT_W'(1);
      end else if (!do_wr && do_rd) begin
         count_d = count_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/fpmul_arbiter.sv
// Round-robin sharing of one combinational fp32 multiplier among NREQ requesters,
// with credit-limited issue, a fixed-latency tag pipeline and in-order responses.
module fpmul_arbiter
   import fpmul_pkg::*;
#(
   parameter int NREQ  = 4,
   parameter int LAT   = 2,
   parameter int DEPTH = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NREQ-1:0]         req_valid,
   output logic [NREQ-1:0]         req_ready,
   input  fp32_t [NREQ-1:0]        req_a,
   input  fp32_t [NREQ-1:0]        req_b,
   output fp32_t                   mul_a,
   output fp32_t                   mul_b,
   input  fp32_t                   mul_op,
   output logic                    rsp_valid,
   input  logic                    rsp_ready,
   output fp32_t                   rsp_data,
   output logic [$clog2(NREQ)-1:0] rsp_id
);

   localparam int ID_W  = $clog2(NREQ);
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEPTH);
   localparam logic [ID_W-1:0]  PTR_LAST = ID_W'(NREQ - 1);

   logic [ID_W-1:0]          ptr_q, ptr_d, gnt_idx, cand;
   logic [CNT_W-1:0]         cnt_q, cnt_d;
   logic                     gnt_found, grant, pop;
   fp32_t                    mul_a_q, mul_a_d, mul_b_q, mul_b_d;
   tag_t                     tag0_q, tag0_d;
   tag_t                     cap_tag;
   fp32_t                    cap_data;
   logic [TAG_ID_W+FP_W-1:0] head;
   logic                     fifo_full, fifo_empty;

   always_comb begin
      gnt_found = 1'b0;
      gnt_idx   = '0;
      cand      = '0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         cand = ID_W'((k + 32'(ptr_q)) % NREQ);
         if (!gnt_found && req_valid[cand]) begin
            gnt_found = 1'b1;
            gnt_idx   = cand;
         end
      end
   end

   // Reset gates the grant so req_ready is low while rst_n is asserted.
   assign grant = rst_n && gnt_found && (cnt_q < CNT_MAX);
   assign pop   = rsp_valid && rsp_ready;

   always_comb begin
      req_ready = '0;
      req_ready[gnt_idx] = grant;
      ptr_d   = ptr_q;
      mul_a_d = mul_a_q;
      mul_b_d = mul_b_q;
      tag0_d  = '0;
      cnt_d   = cnt_q;
      if (grant) begin
         ptr_d     = (gnt_idx == PTR_LAST) ? '0 : gnt_idx + ID_W'(1);
         mul_a_d   = req_a[gnt_idx];
         mul_b_d   = req_b[gnt_idx];
         tag0_d.v  = 1'b1;
         tag0_d.id = TAG_ID_W'(gnt_idx);
      end
      if (grant && !pop) begin
         cnt_d = cnt_q + CNT_W'(1);
      end else if (!grant && pop) begin
         cnt_d = cnt_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q   <= '0;
         cnt_q   <= '0;
         mul_a_q <= '0;
         mul_b_q <= '0;
         tag0_q  <= '0;
      end else begin
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
         mul_a_q <= mul_a_d;
         mul_b_q <= mul_b_d;
         tag0_q  <= tag0_d;
      end
   end

   assign mul_a = mul_a_q;
   assign mul_b = mul_b_q;

   if (LAT == 1) begin : g_direct
      assign cap_tag  = tag0_q;
      assign cap_data = mul_op;
   end else begin : g_delay
      tag_t  tag_q [LAT-1];
      tag_t  tag_d [LAT-1];
      fp32_t dat_q [LAT-1];
      fp32_t dat_d [LAT-1];

      always_comb begin
         tag_d    = tag_q;
         dat_d    = dat_q;
         tag_d[0] = tag0_q;
         dat_d[0] = mul_op;
         for (int unsigned s = 1; s < LAT - 1; s++) begin
            tag_d[s] = tag_q[s-1];
            dat_d[s] = dat_q[s-1];
         end
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            for (int unsigned s = 0; s < LAT - 1; s++) begin
               tag_q[s] <= '0;
               dat_q[s] <= '0;
            end
         end else begin
            tag_q <= tag_d;
            dat_q <= dat_d;
         end
      end

      assign cap_tag  = tag_q[LAT-2];
      assign cap_data = dat_q[LAT-2];
   end

   fpmul_rsp_fifo #(
      .DEPTH(DEPTH),
      .WIDTH(TAG_ID_W + FP_W)
   ) u_rsp_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (cap_tag.v),
      .wr_data ({cap_tag.id, cap_data}),
      .rd_en   (pop),
      .rd_data (head),
      .empty   (fifo_empty),
      .full    (fifo_full)
   );

   assign rsp_valid = !fifo_empty;
   assign rsp_data  = head[FP_W-1:0];
   assign rsp_id    = head[FP_W +: ID_W];

   a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
      !(cap_tag.v && fifo_full && !pop));
   a_gnt_onehot: assert property (@(posedge clk) disable iff (!rst_n)
      $onehot0(req_ready));
   a_cnt_range: assert property (@(posedge clk) disable iff (!rst_n)
      cnt_q <= CNT_MAX);
   a_id_range: assert property (@(posedge clk) disable iff (!rst_n)
      !rsp_valid || (head[FP_W +: TAG_ID_W] <= TAG_ID_W'(NREQ - 1)));

endmodule

// File: tb/tb_fpmul_arbiter.sv
// Scoreboard bench for fpmul_arbiter with a bench-side fp32 multiplier model.
module tb_fpmul_arbiter;

   localparam int NREQ  = 4;
   localparam int LAT   = 2;
   localparam int DEPTH = 4;

   typedef struct {
      int          id;
      logic [31:0] data;
      int          due;
   } sb_entry_t;

   logic                   clk;
   logic                   rst_n;
   logic [NREQ-1:0]        req_valid;
   logic [NREQ-1:0]        req_ready;
   logic [NREQ-1:0][31:0]  req_a;
   logic [NREQ-1:0][31:0]  req_b;
   logic [31:0]            mul_a, mul_b, mul_op;
   logic                   rsp_valid;
   logic                   rsp_ready;
   logic [31:0]            rsp_data;
   logic [1:0]             rsp_id;

   int        n_checks = 0;
   int        n_fail   = 0;
   int        n_grants = 0;
   int        cyc      = 0;
   sb_entry_t sb[$];

   // Truncating fp32 multiply for normal operands; stands in for the real multiplier.
   function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
      logic [47:0] p;
      logic [9:0]  e;
      logic [22:0] f;
      p = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
      e = 10'(a[30:23]) + 10'(b[30:23]) - 10'd127;
      if (p[47]) begin
         f = p[46:24];
         e = e + 10'd1;
      end else begin
         f = p[45:23];
      end
      return {a[31] ^ b[31], e[7:0], f};
   endfunction

   function automatic logic [31:0] rand_fp();
      logic [31:0] r;
      r        = $urandom;
      r[30:23] = 8'($urandom_range(150, 100));
      return r;
   endfunction

   assign mul_op = fmul(mul_a, mul_b);

   fpmul_arbiter #(
      .NREQ(NREQ),
      .LAT(LAT),
      .DEPTH(DEPTH)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .mul_a     (mul_a),
      .mul_b     (mul_b),
      .mul_op    (mul_op),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_data  (rsp_data),
      .rsp_id    (rsp_id)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   // Reference model of arbitration, credits and response ordering, sampled mid-cycle.
   initial begin : monitor
      int          ptr_m, cnt_m, gi;
      bit          found, gnt, exp_v, pop;
      logic [31:0] exp_rdy;
      ptr_m = 0;
      cnt_m = 0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            ptr_m = 0;
            cnt_m = 0;
            sb.delete();
         end else begin
            found = 1'b0;
            gi    = 0;
            for (int k = 0; k < NREQ; k++) begin
               if (!found && req_valid[(ptr_m + k) % NREQ]) begin
                  found = 1'b1;
                  gi    = (ptr_m + k) % NREQ;
               end
            end
            gnt     = found && (cnt_m < DEPTH);
            exp_rdy = gnt ? 32'(1 << gi) : 32'd0;
            check_eq("req_ready", 32'(req_ready), exp_rdy);
            exp_v = (sb.size() > 0) && (sb[0].due <= cyc);
            check_eq("rsp_valid", 32'(rsp_valid), 32'(exp_v));
            pop = exp_v && rsp_ready;
            if (exp_v) begin
               check_eq("rsp_id", 32'(rsp_id), 32'(sb[0].id));
               check_eq("rsp_data", rsp_data, sb[0].data);
            end
            if (pop) void'(sb.pop_front());
            if (gnt) begin
               sb.push_back('{id: gi, data: fmul(req_a[gi], req_b[gi]), due: cyc + LAT + 1});
               ptr_m = (gi + 1) % NREQ;
               n_grants++;
            end
            cnt_m = cnt_m + (gnt ? 1 : 0) - (pop ? 1 : 0);
         end
      end
   end

   task automatic new_ops();
      for (int i = 0; i < NREQ; i++) begin
         req_a[i] = rand_fp();
         req_b[i] = rand_fp();
      end
   endtask

   task automatic do_reset(input logic [NREQ-1:0] v);
      @(posedge clk); #1;
      rst_n     = 1'b0;
      req_valid = '0;
      rsp_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      req_valid = v;
      rsp_ready = 1'b1;
      rst_n     = 1'b1;
   endtask

   task automatic drain(input string tag);
      int n;
      n = 0;
      req_valid = '0;
      rsp_ready = 1'b1;
      while (sb.size() != 0 && n < 50) begin
         @(negedge clk);
         n++;
      end
      @(posedge clk); #1;
      check_eq(tag, 32'(sb.size()), 32'd0);
      check_eq({tag, "_valid"}, 32'(rsp_valid), 32'd0);
   endtask

   task automatic single_op(input int r, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] exp_d);
      int waited;
      @(posedge clk); #1;
      req_valid    = '0;
      req_valid[r] = 1'b1;
      req_a[r]     = a;
      req_b[r]     = b;
      @(negedge clk);
      check_eq("single_gnt", 32'(req_ready), 32'(1 << r));
      @(posedge clk); #1;
      req_valid = '0;
      check_eq("single_mul_a", mul_a, a);
      check_eq("single_mul_b", mul_b, b);
      waited = 0;
      do begin
         @(negedge clk);
         waited++;
      end while (!rsp_valid && waited < 20);
      check_eq("single_latency", 32'(waited), 32'(LAT + 1));
      check_eq("single_data", rsp_data, exp_d);
      check_eq("single_id", 32'(rsp_id), 32'(r));
   endtask

   initial begin : main
      int grants, start;
      rst_n     = 1'b0;
      req_valid = '0;
      req_a     = '0;
      req_b     = '0;
      rsp_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      req_valid = '1;
      #1;
      check_eq("rst_req_ready", 32'(req_ready), 32'd0);
      check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check_eq("rst_mul_a", mul_a, 32'd0);
      check_eq("rst_mul_b", mul_b, 32'd0);
      check_eq("rst_rsp_data", rsp_data, 32'd0);
      check_eq("rst_rsp_id", 32'(rsp_id), 32'd0);
      req_valid = '0;
      @(posedge clk); #1;
      rst_n     = 1'b1;
      rsp_ready = 1'b1;

      single_op(2, 32'h4000_0000, 32'h4040_0000, 32'h40C0_0000);
      @(posedge clk); #1;
      drain("single_drain");

      // All requesters valid from reset: strict rotation at one grant per cycle.
      new_ops();
      do_reset('1);
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         check_eq("rr_gnt", 32'(req_ready), 32'(1 << (i % NREQ)));
         if (i >= 3) check_eq("rr_cnt_hold", 32'(dut.cnt_q), 32'(DEPTH - 1));
         @(posedge clk); #1;
         new_ops();
      end
      drain("rr_drain");

      // Backpressure: credits run out after DEPTH grants.
      do_reset('0);
      rsp_ready = 1'b0;
      req_valid = '1;
      new_ops();
      grants = 0;
      repeat (8) begin
         @(negedge clk);
         if (req_ready != '0) grants++;
         @(posedge clk); #1;
         new_ops();
      end
      check_eq("bp_grants", 32'(grants), 32'(DEPTH));
      check_eq("bp_ready_low", 32'(req_ready), 32'd0);
      check_eq("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      rsp_ready = 1'b1;
      @(negedge clk);
      check_eq("bp_pop_cycle", 32'(req_ready), 32'd0);
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      @(negedge clk);
      check_eq("bp_one_more", 32'(req_ready), 32'd1);
      @(posedge clk); #1;
      @(negedge clk);
      check_eq("bp_blocked_again", 32'(req_ready), 32'd0);
      @(posedge clk); #1;
      drain("bp_drain");

      // Random traffic with random backpressure.
      do_reset('0);
      start = n_grants;
      for (int c = 0; c < 6000 && (n_grants - start) < 1000; c++) begin
         @(posedge clk); #1;
         req_valid = NREQ'($urandom);
         rsp_ready = ($urandom_range(9, 0) < 7);
         new_ops();
      end
      check_eq("rand_ops_done", 32'((n_grants - start) >= 1000), 32'd1);
      @(posedge clk); #1;
      drain("rand_drain");

      // Reset with operations in the pipeline and FIFO.
      do_reset('0);
      rsp_ready = 1'b0;
      req_valid = '1;
      new_ops();
      repeat (3) begin
         @(posedge clk); #1;
      end
      req_valid = '0;
      check_eq("mid_pre_valid", 32'(rsp_valid), 32'd1);
      #2;
      rst_n     = 1'b0;
      req_valid = '1;
      #1;
      check_eq("mid_req_ready", 32'(req_ready), 32'd0);
      check_eq("mid_rsp_valid", 32'(rsp_valid), 32'd0);
      check_eq("mid_mul_a", mul_a, 32'd0);
      check_eq("mid_mul_b", mul_b, 32'd0);
      check_eq("mid_rsp_data", rsp_data, 32'd0);
      check_eq("mid_rsp_id", 32'(rsp_id), 32'd0);
      repeat (2) @(posedge clk);
      #1;
      req_valid = '0;
      rsp_ready = 1'b1;
      rst_n     = 1'b1;
      repeat (5) begin
         @(negedge clk);
         check_eq("mid_idle_valid", 32'(rsp_valid), 32'd0);
      end
      single_op(1, 32'h3FC0_0000, 32'hC000_0000, 32'hC040_0000);
      @(posedge clk); #1;
      drain("mid_drain");

      // Sparse requests: lone requesters are granted immediately and move the pointer.
      do_reset('0);
      @(posedge clk); #1;
      req_valid = 4'b1000;
      @(negedge clk);
      check_eq("sparse_gnt3", 32'(req_ready), 32'b1000);
      @(posedge clk); #1;
      check_eq("sparse_ptr0", 32'(dut.ptr_q), 32'd0);
      req_valid = 4'b0010;
      @(negedge clk);
      check_eq("sparse_gnt1", 32'(req_ready), 32'b0010);
      @(posedge clk); #1;
      req_valid = '0;
      check_eq("sparse_ptr2", 32'(dut.ptr_q), 32'd2);
      drain("sparse_drain");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
